hier_include_sized_fifo: RTL

Parametrised ready/valid FIFO whose depth defaults to the hierarchy-wide `ANOTHER_SIZE` constant (4), imported through `hierIncludeTop_package`. It generalises the fixed-size constant into a configurable buffer that supports:
- arbitrary width and depth, including non-power-of-two depth;
- synchronous flush;
- an almost-full threshold;
- a sticky high-water mark for sizing studies.

It sits between a producer and a consumer inside the hierIncludeTop hierarchy.

---
 rtl/hier_include_sized_fifo_if.sv | 28 ++
 rtl/hier_include_sized_fifo.sv | 87 ++++++++
 2 files changed

// File: rtl/hier_include_sized_fifo_if.sv
// Ready/valid push and pop channels plus flush, high-water and status
// signals for hier_include_sized_fifo. The FIFO side uses the slave modport.
interface hier_include_sized_fifo_if #(
  parameter int DATA_WIDTH = 32,
  parameter int CW         = 3
);
  logic                  push_valid;
  logic                  push_ready;
  logic [DATA_WIDTH-1:0] push_data;
  logic                  pop_valid;
  logic                  pop_ready;
  logic [DATA_WIDTH-1:0] pop_data;
  logic                  flush;
  logic                  hwm_clr;
  logic [CW-1:0]         count;
  logic                  almost_full;
  logic [CW-1:0]         hwm;

  modport master (
    output push_valid, push_data, pop_ready, flush, hwm_clr,
    input  push_ready, pop_valid, pop_data, count, almost_full, hwm
  );

  modport slave (
    input  push_valid, push_data, pop_ready, flush, hwm_clr,
    output push_ready, pop_valid, pop_data, count, almost_full, hwm
  );
endinterface

// File: rtl/hier_include_sized_fifo.sv
// Parametrised ready/valid FIFO with flush, almost-full and a sticky
// high-water mark. Depth defaults to the hierarchy-wide ANOTHER_SIZE.
package hierIncludeTop_package;
  parameter int ANOTHER_SIZE = 4;
endpackage

module hier_include_sized_fifo
  import hierIncludeTop_package::*;
#(
  parameter int DATA_WIDTH   = 32,
  parameter int DEPTH        = ANOTHER_SIZE,
  parameter int AFULL_THRESH = DEPTH - 1,
  localparam int CW          = $clog2(DEPTH + 1)
) (
  input logic                    clk,
  input logic                    rst,
  hier_include_sized_fifo_if.slave fifo_if
);
  localparam int PW = $clog2(DEPTH);
  localparam logic [CW-1:0] DEPTH_C = CW'(DEPTH);
  localparam logic [CW-1:0] AFULL_C = CW'(AFULL_THRESH);
  localparam logic [PW-1:0] LAST_C  = PW'(DEPTH - 1);

  logic [DATA_WIDTH-1:0] mem_q [DEPTH];
  logic [PW-1:0]         wr_ptr_q, wr_ptr_d;
  logic [PW-1:0]         rd_ptr_q, rd_ptr_d;
  logic [CW-1:0]         count_q, count_d;
  logic [CW-1:0]         hwm_q, hwm_d;
  logic                  push_fire, pop_fire;

  // Explicit wrap so non-power-of-two depths never index past DEPTH-1.
  function automatic logic [PW-1:0] nextPtr(input logic [PW-1:0] p);
    return (p == LAST_C) ? '0 : p + 1'b1;
  endfunction

  assign fifo_if.push_ready  = !fifo_if.flush && (count_q != DEPTH_C);
  assign fifo_if.pop_valid   = (count_q != '0);
  assign fifo_if.pop_data    = mem_q[rd_ptr_q];
  assign fifo_if.count       = count_q;
  assign fifo_if.almost_full = (count_q >= AFULL_C);
  assign fifo_if.hwm         = hwm_q;

  assign push_fire = fifo_if.push_valid && fifo_if.push_ready;
  assign pop_fire  = fifo_if.pop_valid && fifo_if.pop_ready;

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (fifo_if.flush) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      count_d  = '0;
    end else begin
      if (push_fire) wr_ptr_d = nextPtr(wr_ptr_q);
      if (pop_fire)  rd_ptr_d = nextPtr(rd_ptr_q);
      if (push_fire && !pop_fire)      count_d = count_q + 1'b1;
      else if (!push_fire && pop_fire) count_d = count_q - 1'b1;
    end
  end

  // Clear wins over the running maximum; flush leaves the mark alone.
  always_comb begin
    hwm_d = hwm_q;
    if (fifo_if.hwm_clr)      hwm_d = count_d;
    else if (count_d > hwm_q) hwm_d = count_d;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      hwm_q    <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
      hwm_q    <= hwm_d;
    end
  end

  // Storage is deliberately left out of reset.
  always_ff @(posedge clk) begin
    if (push_fire) mem_q[wr_ptr_q] <= fifo_if.push_data;
  end
endmodule
